// File: rtl/sel_rr_arbiter4.sv
// Round-robin scheduler sharing a 4-path selector (feeds a sel2to4 decoder).
// One owner at a time, held while its req stays high, cut after MAX_HOLD
// cycles, with a dead cycle between consecutive grants (break-before-make).
module sel_rr_arbiter4 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic [3:0]       req,
  output logic [1:0]       select,
  output logic [3:0]       grant,
  output logic             valid,
  output logic [CNT_W-1:0] hold_cnt,
  output logic             timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Last hold_cnt value an owner may reach before being cut off.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       select_q, select_d;
  logic [3:0]       grant_q, grant_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;

  logic [1:0]       winner;
  logic             req_any;
  logic             owner_req;
  logic             at_limit;

  assign req_any   = |req;
  assign owner_req = req[select_q];
  assign at_limit  = (hold_cnt_q == HOLD_LAST);

  // Rotating priority search: first requester at or after ptr (mod 4).
  always_comb begin
    winner = ptr_q;
    // Scan from farthest to nearest so the nearest requester overwrites last.
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr_q + 2'(k)]) begin
        winner = ptr_q + 2'(k);
      end
    end
  end

  // Next-state and output decode for the IDLE/GRANT controller.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    ptr_d      = ptr_q;
    select_d   = select_q;
    grant_d    = grant_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          select_d   = winner;
          grant_d    = 4'b0001 << winner;
          hold_cnt_d = '0;
          state_d    = GRANT;
        end else begin
          // select keeps the last owner's code while idle.
          grant_d = 4'b0000;
        end
      end
      GRANT: begin
        if (!owner_req || at_limit) begin
          // Voluntary release wins over forced: a forced cut is flagged only
          // when the owner still wanted the path.
          grant_d    = 4'b0000;
          hold_cnt_d = '0;
          timeout_d  = owner_req;
          ptr_d      = select_q + 2'd1;
          state_d    = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        grant_d    = 4'b0000;
        hold_cnt_d = '0;
        state_d    = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk1) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      select_q   <= 2'd0;
      grant_q    <= 4'b0000;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      select_q   <= select_d;
      grant_q    <= grant_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign select   = select_q;
  assign grant    = grant_q;
  assign valid    = |grant_q;
  assign hold_cnt = hold_cnt_q;
  assign timeout  = timeout_q;

endmodule
